// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite widths, bus encodings and the data-phase control types
// used by the slave subsystem.
package ahb_lite_pkg;

    localparam int AHB_ADDR_WIDTH  = 32;
    localparam int AHB_DATA_WIDTH  = 32;
    localparam int AHB_TRANS_WIDTH = 2;
    localparam int AHB_SIZE_WIDTH  = 3;
    localparam int AHB_BURST_WIDTH = 3;
    localparam int AHB_PROT_WIDTH  = 4;
    localparam int AHB_RESP_WIDTH  = 1;
    localparam int AHB_READY_WIDTH = 1;
    localparam int BYTE_WIDTH      = 8;

    typedef enum logic [AHB_TRANS_WIDTH-1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } HTRANS_e;

    typedef enum logic [AHB_SIZE_WIDTH-1:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } HSIZE_e;

    typedef enum logic [AHB_BURST_WIDTH-1:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } HBURST_e;

    typedef enum logic [AHB_RESP_WIDTH-1:0] {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_e;

    typedef enum logic [AHB_READY_WIDTH-1:0] {
        READY_WAIT = 1'b0,
        READY_DONE = 1'b1
    } HREADY_e;

    typedef enum logic {
        XFER_READ  = 1'b0,
        XFER_WRITE = 1'b1
    } HWRITE_e;

    typedef enum logic [1:0] {
        SEL_MEM0    = 2'd0,
        SEL_MEM1    = 2'd1,
        SEL_MEM2    = 2'd2,
        SEL_DEFAULT = 2'd3
    } HSEL_e;

    // What the bus is doing in the current data phase; the two ERR states are
    // the two cycles of the ERROR response.
    typedef enum logic [2:0] {
        DP_IDLE  = 3'd0,
        DP_READ  = 3'd1,
        DP_WRITE = 3'd2,
        DP_ERR1  = 3'd3,
        DP_ERR2  = 3'd4
    } dp_state_e;

    function automatic logic [3:0] lane_strb(input logic [AHB_SIZE_WIDTH-1:0] size,
                                             input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic size_aligned(input logic [AHB_SIZE_WIDTH-1:0] size,
                                          input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~off[0];
            SIZE_WORD: ok = (off == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_mem_slave.sv
// Zero-wait word memory with byte-lane writes; a read captured in the same
// cycle as a write to the same word sees the merged word.
module ahb_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int DATA_WIDTH = AHB_DATA_WIDTH,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_strb,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    localparam int STRB_W = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] fwd_word;

    always_comb begin
        fwd_word = mem[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    fwd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Contents deliberately survive HRESETn; only the control path resets.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem[wr_idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= fwd_word;
        end
    end

endmodule

// File: rtl/ahb_lite_modport.sv
// AHB-Lite slave subsystem: address decoder, three memory slaves, default
// ERROR slave and data-phase response mux.
module ahb_lite_modport
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = AHB_DATA_WIDTH,
    parameter int SEL_WIDTH  = 2,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       HRESETn,
    input  logic                       HWRITE,
    input  logic [AHB_TRANS_WIDTH-1:0] HTRANS,
    input  logic [AHB_SIZE_WIDTH-1:0]  HSIZE,
    input  logic [AHB_BURST_WIDTH-1:0] HBURST,
    input  logic [AHB_PROT_WIDTH-1:0]  HPROT,
    input  logic [ADDR_WIDTH-1:0]      HADDR,
    input  logic [DATA_WIDTH-1:0]      HWDATA,
    output logic [DATA_WIDTH-1:0]      HRDATA,
    output logic [AHB_RESP_WIDTH-1:0]  HRESP,
    output logic [AHB_READY_WIDTH-1:0] HREADY
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int N_MEM  = 3;
    localparam int STRB_W = DATA_WIDTH / BYTE_WIDTH;

    typedef struct packed {
        logic [SEL_WIDTH-1:0] sel;
        logic [IDX_W-1:0]     idx;
        logic [STRB_W-1:0]    strb;
    } dp_ctrl_t;

    dp_state_e             state;
    dp_state_e             state_nxt;
    dp_ctrl_t              dp;
    logic [SEL_WIDTH-1:0]  a_sel;
    logic [IDX_W-1:0]      a_idx;
    logic                  a_legal;
    logic                  accept;
    logic [DATA_WIDTH-1:0] mem_rdata [N_MEM];
    logic                  unused_ok;

    assign a_sel   = HADDR[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign a_idx   = HADDR[IDX_W+1:2];
    assign a_legal = (a_sel < SEL_WIDTH'(N_MEM)) && size_aligned(HSIZE, HADDR[1:0]);

    // Handshake: an address phase is taken at a rising edge only when HREADY
    // is high and HTRANS is NONSEQ or SEQ; the following cycle is its data
    // phase, which ends at the first rising edge where HREADY is high.
    assign accept = (HREADY == READY_DONE) &&
                    ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

    // Burst type, protection and the aliasing offset bits do not affect decode.
    assign unused_ok = ^{HBURST, HPROT, HADDR[ADDR_WIDTH-SEL_WIDTH-1:IDX_W+2]};

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = DP_IDLE;
        if (state == DP_ERR1) begin
            state_nxt = DP_ERR2;
        end else if (accept) begin
            if (!a_legal) begin
                state_nxt = DP_ERR1;
            end else if (HWRITE == XFER_WRITE) begin
                state_nxt = DP_WRITE;
            end else begin
                state_nxt = DP_READ;
            end
        end
    end

    always_comb begin
        HREADY = READY_DONE;
        HRESP  = OKAY;
        HRDATA = '0;
        case (state)
            DP_READ: begin
                for (int i = 0; i < N_MEM; i++) begin
                    if (dp.sel == SEL_WIDTH'(i)) begin
                        HRDATA = mem_rdata[i];
                    end
                end
            end
            DP_ERR1: begin
                HREADY = READY_WAIT;
                HRESP  = ERROR;
            end
            DP_ERR2: HRESP = ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            dp <= '0;
        end else if (accept) begin
            dp.sel  <= a_sel;
            dp.idx  <= a_idx;
            dp.strb <= lane_strb(HSIZE, HADDR[1:0]);
        end
    end

    // Reads are captured at the address-phase edge, so the slave forwards
    // any write whose data phase completes on that same edge.
    for (genvar g = 0; g < N_MEM; g++) begin : g_mem
        ahb_mem_slave #(
            .DATA_WIDTH(DATA_WIDTH),
            .MEM_DEPTH (MEM_DEPTH),
            .IDX_W     (IDX_W)
        ) u_mem (
            .clk    (clk),
            .rst_n  (HRESETn),
            .wr_en  ((state == DP_WRITE) && (dp.sel == SEL_WIDTH'(g))),
            .wr_idx (dp.idx),
            .wr_strb(dp.strb),
            .wr_data(HWDATA),
            .rd_en  (accept && a_legal && (HWRITE == XFER_READ) && (a_sel == SEL_WIDTH'(g))),
            .rd_idx (a_idx),
            .rd_data(mem_rdata[g])
        );
    end

endmodule

// File: tb/tb_ahb_lite_modport.sv
// Directed bench for ahb_lite_modport: the driver queues the expected
// {HREADY, HRESP, HRDATA} of every cycle; a negedge monitor checks them.
module tb_ahb_lite_modport;
    import ahb_lite_pkg::*;

    logic        clk;
    logic        HRESETn;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [0:0]  HRESP;
    logic [0:0]  HREADY;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [33:0] exp_q[$];
    string       name_q[$];

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NS   = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;

    ahb_lite_modport dut (
        .clk    (clk),
        .HRESETn(HRESETn),
        .HWRITE (HWRITE),
        .HTRANS (HTRANS),
        .HSIZE  (HSIZE),
        .HBURST (HBURST),
        .HPROT  (HPROT),
        .HADDR  (HADDR),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .HRESP  (HRESP),
        .HREADY (HREADY)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic drive(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata);
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = addr;
        HWDATA = wdata;
        HBURST = 3'($urandom_range(0, 7));
        HPROT  = 4'($urandom_range(0, 15));
    endtask

    task automatic expect_out(input logic rdy, input logic resp, input logic [31:0] rd,
                              input string nm);
        exp_q.push_back({rdy, resp, rd});
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rdy, input logic resp, input logic [31:0] rd,
                        input string nm);
        drive(tr, wr, sz, addr, wdata);
        expect_out(rdy, resp, rd, nm);
        tick();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [33:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            vec_cnt++;
            if ({HREADY, HRESP, HRDATA} !== e) begin
                err_cnt++;
                $display("FAIL %s: got hready=%0b hresp=%0b hrdata=%h, expected hready=%0b hresp=%0b hrdata=%h",
                         nm, HREADY, HRESP, HRDATA, e[33], e[32], e[31:0]);
            end
        end
    end

    initial begin
        HRESETn = 1'b0;
        drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        tick();
        expect_out(1'b1, 1'b0, 32'h0, "reset");
        tick();
        expect_out(1'b1, 1'b0, 32'h0, "reset_held");
        tick();
        HRESETn = 1'b1;

        // word write then read
        beat(T_NS,   1'b1, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h0,         "idle0");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'hDEADBEEF,  1'b1, 1'b0, 32'h0,         "wr_10");
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h0,         "idle1");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'hDEADBEEF,  "rd_10");
        // byte and halfword lanes, each read forwarded from the overlapping write
        beat(T_NS,   1'b1, 3'd2, 32'h4000_0000, 32'h0,         1'b1, 1'b0, 32'h0,         "idle2");
        beat(T_NS,   1'b1, 3'd0, 32'h4000_0003, 32'h11223344,  1'b1, 1'b0, 32'h0,         "wr_40_word");
        beat(T_SEQ,  1'b0, 3'd2, 32'h4000_0000, 32'hAA556677,  1'b1, 1'b0, 32'h0,         "wr_43_byte");
        beat(T_NS,   1'b1, 3'd1, 32'h4000_0002, 32'h0,         1'b1, 1'b0, 32'hAA223344,  "rd_40_merged");
        beat(T_NS,   1'b0, 3'd2, 32'h4000_0000, 32'hBEEF1234,  1'b1, 1'b0, 32'h0,         "wr_42_half");
        // back-to-back write/read forwarding, then aliased read
        beat(T_NS,   1'b1, 3'd2, 32'h8000_0020, 32'h0,         1'b1, 1'b0, 32'hBEEF3344,  "rd_40_half");
        beat(T_NS,   1'b0, 3'd2, 32'h8000_0020, 32'h12345678,  1'b1, 1'b0, 32'h0,         "wr_80");
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0410, 32'h0,         1'b1, 1'b0, 32'h12345678,  "rd_80_fwd");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'hDEADBEEF,  "rd_alias");
        beat(T_NS,   1'b0, 3'd2, 32'h8000_0020, 32'h0,         1'b1, 1'b0, 32'h0,         "idle3");
        // default slave read: two-cycle ERROR, next transfer accepted in cycle 2
        beat(T_NS,   1'b0, 3'd2, 32'hC000_0000, 32'h0,         1'b1, 1'b0, 32'h12345678,  "rd_80");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0,         "err_rd_c1");
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 32'h0,         "err_rd_c2");
        beat(T_NS,   1'b1, 3'd2, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'hDEADBEEF,  "rd_after_err");
        // misaligned half, HSIZE=3 and default-slave writes must not commit
        beat(T_NS,   1'b1, 3'd1, 32'h0000_0001, 32'hCAFE0001,  1'b1, 1'b0, 32'h0,         "wr_00");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'hFFFFFFFF,  1'b0, 1'b1, 32'h0,         "mis_c1");
        beat(T_NS,   1'b1, 3'd3, 32'h0000_0000, 32'hFFFFFFFF,  1'b1, 1'b1, 32'h0,         "mis_c2");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'hFFFFFFFF,  1'b0, 1'b1, 32'h0,         "sz3_c1");
        beat(T_NS,   1'b1, 3'd2, 32'hC000_0010, 32'hFFFFFFFF,  1'b1, 1'b1, 32'h0,         "sz3_c2");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'hFFFFFFFF,  1'b0, 1'b1, 32'h0,         "dflt_wr_c1");
        // IDLE and BUSY with write intent: OKAY, zero wait, no access
        beat(T_IDLE, 1'b1, 3'd2, 32'h0000_0000, 32'hFFFFFFFF,  1'b1, 1'b1, 32'h0,         "dflt_wr_c2");
        beat(T_BUSY, 1'b1, 3'd2, 32'h0000_0000, 32'hFFFFFFFF,  1'b1, 1'b0, 32'h0,         "idle_okay");
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0000, 32'hFFFFFFFF,  1'b1, 1'b0, 32'h0,         "busy_okay");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'hCAFE0001,  "rd_00_unchanged");
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h0,         "idle4");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'hDEADBEEF,  "rd_10_after_dflt");

        // reset during a read data phase clears HRDATA at once
        beat(T_NS,   1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'h0,         "idle5");
        drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
        HRESETn = 1'b0;
        expect_out(1'b1, 1'b0, 32'h0, "rst_mid_rd");
        tick();
        expect_out(1'b1, 1'b0, 32'h0, "rst_held1");
        tick();
        HRESETn = 1'b1;

        // reset during a write data phase drops the write
        beat(T_NS,   1'b1, 3'd2, 32'h8000_0024, 32'h0,         1'b1, 1'b0, 32'h0,         "idle6");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h55AA55AA,  1'b1, 1'b0, 32'h0,         "wr_84");
        beat(T_NS,   1'b1, 3'd2, 32'h8000_0024, 32'h0,         1'b1, 1'b0, 32'h0,         "idle7");
        drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF);
        HRESETn = 1'b0;
        expect_out(1'b1, 1'b0, 32'h0, "rst_mid_wr");
        tick();
        expect_out(1'b1, 1'b0, 32'h0, "rst_held2");
        tick();
        HRESETn = 1'b1;
        beat(T_NS,   1'b0, 3'd2, 32'h8000_0024, 32'h0,         1'b1, 1'b0, 32'h0,         "idle8");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'h55AA55AA,  "rd_84_unchanged");
        beat(T_IDLE, 1'b0, 3'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         "idle_end");

        // final report
        @(negedge clk);
        #1;
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
